// File: rtl/tape_progress_tracker_if.sv
// Media-loader to progress-overlay signal bundle: loader strobes in, bar controls out.
interface tape_progress_tracker_if;
   logic        vblank;
   logic        start;
   logic [24:0] size;
   logic        byte_stb;
   logic        motor;
   logic        abort;
   logic        enable;
   logic [24:0] current;
   logic [24:0] max;
   logic        done;

   modport master (
      output vblank, start, size, byte_stb, motor, abort,
      input  enable, current, max, done
   );

   modport slave (
      input  vblank, start, size, byte_stb, motor, abort,
      output enable, current, max, done
   );
endinterface

// File: rtl/tape_progress_tracker.sv
// Loading-bar producer: latches transfer size, counts consumed bytes, hides the bar after hold/stall.
// Outputs registered, 1 cycle after the cause; no backpressure, every strobe is taken or dropped at once.
module tape_progress_tracker #(
   parameter logic [7:0] HOLD_FRAMES  = 8'd50,
   parameter logic [7:0] STALL_FRAMES = 8'd100
) (
   input  logic                    clk,
   input  logic                    reset,
   tape_progress_tracker_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]  state, state_nx;
   logic [24:0] cnt, cnt_nx;
   logic [24:0] size_l, size_l_nx;
   logic [7:0]  frm, frm_nx, frm_inc;
   logic        sh7, sh7_nx;
   logic        full, full_nx;
   logic        done_nx;
   logic        vb_d, motor_d;
   logic        ftick, motor_rise;
   logic [24:0] cur_nx, max_nx;

   assign ftick      = bus.vblank & ~vb_d;
   assign motor_rise = bus.motor & ~motor_d;
   assign frm_inc    = (frm == 8'hFF) ? frm : frm + 8'd1;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      size_l_nx = size_l;
      frm_nx    = frm;
      sh7_nx    = sh7;
      full_nx   = full;
      done_nx   = 1'b0;
      if (bus.abort) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
         frm_nx   = '0;
         full_nx  = 1'b0;
      end else if (bus.start) begin
         size_l_nx = bus.size;
         cnt_nx    = '0;
         frm_nx    = '0;
         sh7_nx    = (bus.size < 25'd128);
         if (bus.size == '0) begin
            // Empty image: show a full bar immediately.
            state_nx = ST_HOLD;
            done_nx  = 1'b1;
            full_nx  = 1'b1;
         end else begin
            state_nx = ST_RUN;
            full_nx  = 1'b0;
         end
      end else if (bus.byte_stb && (state == ST_RUN || state == ST_STALL)) begin
         frm_nx   = '0;
         state_nx = ST_RUN;
         if (cnt != size_l) cnt_nx = cnt + 25'd1;
         if ((cnt + 25'd1) == size_l) begin
            done_nx  = 1'b1;
            state_nx = ST_HOLD;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (ftick) frm_nx = frm_inc;
               if (!bus.motor && frm_nx >= STALL_FRAMES) begin
                  state_nx = ST_STALL;
                  frm_nx   = '0;
               end
            end
            ST_STALL: begin
               if (motor_rise) begin
                  state_nx = ST_RUN;
                  frm_nx   = '0;
               end else if (ftick && !bus.motor) begin
                  frm_nx = frm_inc;
                  if (frm_inc >= STALL_FRAMES) state_nx = ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (ftick) begin
                  frm_nx = frm_inc;
                  if (frm_inc >= HOLD_FRAMES) state_nx = ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Short transfers are scaled by 128 so the overlay sees nonzero upper bits.
   always_comb begin
      cur_nx = sh7_nx ? {cnt_nx[17:0], 7'd0}    : cnt_nx;
      max_nx = sh7_nx ? {size_l_nx[17:0], 7'd0} : size_l_nx;
      if (full_nx) begin
         cur_nx = 25'd128;
         max_nx = 25'd128;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         size_l      <= '0;
         frm         <= '0;
         sh7         <= 1'b0;
         full        <= 1'b0;
         vb_d        <= 1'b0;
         motor_d     <= 1'b0;
         bus.enable  <= 1'b0;
         bus.current <= '0;
         bus.max     <= '0;
         bus.done    <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         size_l      <= size_l_nx;
         frm         <= frm_nx;
         sh7         <= sh7_nx;
         full        <= full_nx;
         vb_d        <= bus.vblank;
         motor_d     <= bus.motor;
         bus.enable  <= (state_nx != ST_IDLE);
         bus.current <= cur_nx;
         bus.max     <= max_nx;
         bus.done    <= done_nx;
      end
   end
endmodule

// File: tb/tb_tape_progress_tracker.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_tape_progress_tracker;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;

   typedef struct {
      int    cyc;
      string name;
      logic  en;
      int    cur;
      int    mx;
      logic  dn;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   tape_progress_tracker_if bus();

   tape_progress_tracker #(
      .HOLD_FRAMES (8'd50),
      .STALL_FRAMES(8'd100)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         checks++;
         if (mon_e.cyc != cyc || bus.enable !== mon_e.en || bus.current !== 25'(mon_e.cur) ||
             bus.max !== 25'(mon_e.mx) || bus.done !== mon_e.dn) begin
            errors++;
            $display("FAIL %s cyc=%0d: got en=%0b cur=%0d max=%0d done=%0b, want en=%0b cur=%0d max=%0d done=%0b",
                     mon_e.name, cyc, bus.enable, bus.current, bus.max, bus.done,
                     mon_e.en, mon_e.cur, mon_e.mx, mon_e.dn);
         end
      end
      if (bus.done === 1'b1) done_seen++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_out(string n, logic en, int cur, int mx, logic dn);
      exp_t e;
      e.cyc = cyc; e.name = n; e.en = en; e.cur = cur; e.mx = mx; e.dn = dn;
      q.push_back(e);
   endtask

   task automatic start_xfer(int sz);
      bus.size  = 25'(sz);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic bytes(int n);
      bus.byte_stb = 1'b1;
      repeat (n) step();
      bus.byte_stb = 1'b0;
   endtask

   task automatic frames(int n);
      repeat (n) begin
         bus.vblank = 1'b1;
         step();
         bus.vblank = 1'b0;
         step();
      end
   endtask

   task automatic last_frame();
      bus.vblank = 1'b1;
      step();
      bus.vblank = 1'b0;
   endtask

   initial begin
      bus.vblank = 1'b0; bus.start = 1'b0; bus.size = '0;
      bus.byte_stb = 1'b0; bus.motor = 1'b0; bus.abort = 1'b0;

      reset = 1'b1;
      step(); step();
      exp_out("reset", 0, 0, 0, 0);
      reset = 1'b0;

      // 1) long transfer, unscaled
      bus.motor = 1'b1;
      start_xfer(1000);
      exp_out("t1_start", 1, 0, 1000, 0);
      bus.byte_stb = 1'b1;
      for (int i = 1; i <= 1000; i++) begin
         step();
         exp_out("t1_byte", 1, i, 1000, logic'(i == 1000));
      end
      bus.byte_stb = 1'b0;
      step();
      exp_out("t1_done_once", 1, 1000, 1000, 0);
      bytes(1);
      exp_out("t1_hold_ignore", 1, 1000, 1000, 0);
      frames(49);
      exp_out("t1_hold_49", 1, 1000, 1000, 0);
      last_frame();
      exp_out("t1_hold_end", 0, 1000, 1000, 0);
      bytes(1);
      exp_out("t1_idle_ignore", 0, 1000, 1000, 0);

      // 2) short transfer, scaled by 128
      start_xfer(10);
      exp_out("t2_start", 1, 0, 1280, 0);
      bus.byte_stb = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         exp_out("t2_byte", 1, i * 128, 1280, logic'(i == 10));
      end
      bus.byte_stb = 1'b0;
      step();
      exp_out("t2_after", 1, 1280, 1280, 0);

      // 3) zero-length transfer
      start_xfer(0);
      exp_out("t3_zero", 1, 128, 128, 1);
      step();
      exp_out("t3_pulse_end", 1, 128, 128, 0);
      frames(49);
      exp_out("t3_hold_49", 1, 128, 128, 0);
      last_frame();
      exp_out("t3_hold_end", 0, 128, 128, 0);

      // 4) stall then resume then give up
      bus.motor = 1'b1;
      start_xfer(1000);
      bytes(300);
      exp_out("t4_cnt300", 1, 300, 1000, 0);
      bus.motor = 1'b0;
      frames(100);
      exp_out("t4_stalled", 1, 300, 1000, 0);
      bytes(1);
      exp_out("t4_resume", 1, 301, 1000, 0);
      frames(199);
      exp_out("t4_pre_idle", 1, 301, 1000, 0);
      last_frame();
      exp_out("t4_idle", 0, 301, 1000, 0);

      // 5) abort and start priority over byte strobe
      bus.motor = 1'b1;
      start_xfer(1000);
      exp_out("t5_start", 1, 0, 1000, 0);
      bytes(20);
      exp_out("t5_cnt20", 1, 20, 1000, 0);
      bus.abort = 1'b1; bus.byte_stb = 1'b1;
      step();
      bus.abort = 1'b0; bus.byte_stb = 1'b0;
      exp_out("t5_abort", 0, 0, 1000, 0);
      bus.size = 25'd1000; bus.start = 1'b1; bus.byte_stb = 1'b1;
      step();
      bus.start = 1'b0; bus.byte_stb = 1'b0;
      exp_out("t5_start_drop", 1, 0, 1000, 0);
      bytes(1);
      exp_out("t5_first", 1, 1, 1000, 0);

      // 6) reset while holding
      start_xfer(10);
      bytes(10);
      exp_out("t6_done", 1, 1280, 1280, 1);
      bytes(1);
      exp_out("t6_extra", 1, 1280, 1280, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_out("t6_reset", 0, 0, 0, 0);
      bytes(1);
      exp_out("t6_idle", 0, 0, 0, 0);

      step(); step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL unchecked_queue: got %0d pending, want 0", q.size());
      end
      checks++;
      if (done_seen != 4) begin
         errors++;
         $display("FAIL done_count: got %0d pulses, want 4", done_seen);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
